// File: rtl/mips_cpu_bus.sv
// mips_cpu_bus: multi-cycle MIPS-I subset CPU with a single memory bus.
// Each instruction is fetched (FETCH), executed (EXEC), optionally given a
// data access (MEM, LW/SW only) and then the next fetch starts. The CPU
// halts when the next fetch would be issued at address 0.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high reset
//   active       1 while executing, 0 once halted
//   register_v0  live copy of GPR $2
//   address      word-aligned byte address of the current bus request
//   write/read   bus request strobes (never both set)
//   waitrequest  slave stall; request signals are held while it is 1
//   writedata    store data
//   byteenable   byte lanes of the current request
//   readdata     read data, valid in the cycle a read completes
//
// Optional feature macro: MULDIV_EN adds HI/LO, MULTU, DIVU, MFHI and MFLO.
// Without it those instructions execute as NOP.
module mips_cpu_bus (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;          // address of the instruction in flight
  logic [31:0] npc_reg;         // address of the next instruction (delay slot aware)
  logic [31:0] ir_reg;
  logic [31:0] mem_addr_reg;    // registered so it stays stable under waitrequest
  logic [31:0] store_data_reg;
  logic [31:0] gpr_reg [0:31];

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target26;

  assign op       = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign shamt    = ir_reg[10:6];
  assign funct    = ir_reg[5:0];
  assign imm      = ir_reg[15:0];
  assign target26 = ir_reg[25:0];

  logic [31:0] rs_val, rt_val, imm_sext, imm_zext, pc_plus4, branch_target, mem_ea;

  // $0 is cleared on reset and never written, so it always reads 0.
  assign rs_val        = gpr_reg[rs];
  assign rt_val        = gpr_reg[rt];
  assign imm_sext      = {{16{imm[15]}}, imm};
  assign imm_zext      = {16'd0, imm};
  assign pc_plus4      = pc_reg + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign mem_ea        = rs_val + imm_sext;

  assign register_v0 = gpr_reg[2];
  assign active      = (state_reg != HALT);

`ifdef MULDIV_EN
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] md_rem_reg, md_quot_reg, md_div_reg;
  logic [4:0]  md_cnt_reg;
  logic        md_busy_reg;
  logic [63:0] product;
  logic [32:0] md_shift, md_diff;
  logic [31:0] md_rem_step, md_quot_step;

  assign product = {32'd0, rs_val} * {32'd0, rt_val};

  // One restoring-division step per cycle; a borrow out of bit 32 means
  // the shifted remainder was smaller than the divisor.
  assign md_shift     = {md_rem_reg, md_quot_reg[31]};
  assign md_diff      = md_shift - {1'b0, md_div_reg};
  assign md_rem_step  = md_diff[32] ? md_shift[31:0] : md_diff[31:0];
  assign md_quot_step = {md_quot_reg[30:0], ~md_diff[32]};
`endif

  // Execute-stage decode
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        taken;
  logic [31:0] jump_pc;
  logic        exec_done;
  logic        is_mem;

  always_comb begin
    wb_en     = 1'b0;
    wb_addr   = rd;
    wb_data   = 32'd0;
    taken     = 1'b0;
    jump_pc   = branch_target;
    exec_done = 1'b1;
    is_mem    = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_ADDU:  begin wb_en = 1'b1; wb_data = rs_val + rt_val; end
          F_SUBU:  begin wb_en = 1'b1; wb_data = rs_val - rt_val; end
          F_AND:   begin wb_en = 1'b1; wb_data = rs_val & rt_val; end
          F_OR:    begin wb_en = 1'b1; wb_data = rs_val | rt_val; end
          F_XOR:   begin wb_en = 1'b1; wb_data = rs_val ^ rt_val; end
          F_SLT:   begin wb_en = 1'b1; wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
          F_SLTU:  begin wb_en = 1'b1; wb_data = {31'd0, rs_val < rt_val}; end
          F_SLL:   begin wb_en = 1'b1; wb_data = rt_val << shamt; end
          F_SRL:   begin wb_en = 1'b1; wb_data = rt_val >> shamt; end
          F_SRA:   begin wb_en = 1'b1; wb_data = $signed(rt_val) >>> shamt; end
          F_JR:    begin taken = 1'b1; jump_pc = rs_val; end
`ifdef MULDIV_EN
          F_MFHI:  begin wb_en = 1'b1; wb_data = hi_reg; end
          F_MFLO:  begin wb_en = 1'b1; wb_data = lo_reg; end
          F_MULTU: exec_done = 1'b1;
          // Divide by zero finishes at once and leaves HI/LO untouched.
          F_DIVU:  exec_done = (rt_val == 32'd0) || (md_busy_reg && (md_cnt_reg == 5'd31));
`endif
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZAL || rt == RT_BGEZAL) begin
          // The link is written whether or not the branch is taken.
          wb_en   = 1'b1;
          wb_addr = 5'd31;
          wb_data = pc_reg + 32'd8;
          taken   = (rt == RT_BLTZAL) ? rs_val[31] : ~rs_val[31];
        end
      end
      OP_J:     begin taken = 1'b1; jump_pc = {pc_plus4[31:28], target26, 2'b00}; end
      OP_JAL: begin
        taken   = 1'b1;
        jump_pc = {pc_plus4[31:28], target26, 2'b00};
        wb_en   = 1'b1;
        wb_addr = 5'd31;
        wb_data = pc_reg + 32'd8;
      end
      OP_BEQ:   taken = (rs_val == rt_val);
      OP_BNE:   taken = (rs_val != rt_val);
      OP_ADDIU: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val + imm_sext; end
      OP_SLTI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = {31'd0, $signed(rs_val) < $signed(imm_sext)}; end
      OP_SLTIU: begin wb_en = 1'b1; wb_addr = rt; wb_data = {31'd0, rs_val < imm_sext}; end
      OP_ANDI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val & imm_zext; end
      OP_ORI:   begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val | imm_zext; end
      OP_XORI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val ^ imm_zext; end
      OP_LUI:   begin wb_en = 1'b1; wb_addr = rt; wb_data = {imm, 16'd0}; end
      OP_LW,
      OP_SW:    is_mem = 1'b1;
      default: ;
    endcase
  end

  // Register-file write port: ALU/link results in EXEC, load data in MEM.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_addr;
    rf_wdata = wb_data;
    if (state_reg == EXEC && exec_done && wb_en) begin
      rf_we = 1'b1;
    end else if (state_reg == MEM && op == OP_LW && !waitrequest) begin
      rf_we    = 1'b1;
      rf_waddr = rt;
      rf_wdata = readdata;
    end
  end

  // Next state and bus outputs
  always_comb begin
    state_next = state_reg;
    read       = 1'b0;
    write      = 1'b0;
    address    = 32'd0;
    writedata  = store_data_reg;
    byteenable = 4'b0000;
    case (state_reg)
      FETCH: begin
        read       = 1'b1;
        address    = pc_reg;
        byteenable = 4'b1111;
        if (!waitrequest) state_next = EXEC;
      end
      EXEC: begin
        // npc_reg becomes the PC of the next fetch.
        if (exec_done) begin
          if (is_mem)                  state_next = MEM;
          else if (npc_reg == 32'd0)   state_next = HALT;
          else                         state_next = FETCH;
        end
      end
      MEM: begin
        address    = mem_addr_reg;
        byteenable = 4'b1111;
        if (op == OP_SW) write = 1'b1;
        else             read  = 1'b1;
        // pc_reg was already advanced at the end of EXEC.
        if (!waitrequest) state_next = (pc_reg == 32'd0) ? HALT : FETCH;
      end
      HALT: ;
      default: state_next = HALT;
    endcase
    if (reset) begin
      read  = 1'b0;
      write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      npc_reg        <= RESET_PC + 32'd4;
      ir_reg         <= 32'd0;
      mem_addr_reg   <= 32'd0;
      store_data_reg <= 32'd0;
      for (int i = 0; i < 32; i++) gpr_reg[i] <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH && !waitrequest) ir_reg <= readdata;
      if (state_reg == EXEC && exec_done) begin
        pc_reg         <= npc_reg;
        npc_reg        <= taken ? jump_pc : npc_reg + 32'd4;
        mem_addr_reg   <= mem_ea & ~32'h3;
        store_data_reg <= rt_val;
      end
      if (rf_we && rf_waddr != 5'd0) gpr_reg[rf_waddr] <= rf_wdata;
    end
  end

`ifdef MULDIV_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      md_rem_reg  <= 32'd0;
      md_quot_reg <= 32'd0;
      md_div_reg  <= 32'd0;
      md_cnt_reg  <= 5'd0;
      md_busy_reg <= 1'b0;
    end else if (state_reg == EXEC && op == OP_SPECIAL) begin
      if (funct == F_MULTU) begin
        {hi_reg, lo_reg} <= product;
      end else if (funct == F_DIVU && rt_val != 32'd0) begin
        if (!md_busy_reg) begin
          md_busy_reg <= 1'b1;
          md_rem_reg  <= 32'd0;
          md_quot_reg <= rs_val;
          md_div_reg  <= rt_val;
          md_cnt_reg  <= 5'd0;
        end else begin
          md_rem_reg  <= md_rem_step;
          md_quot_reg <= md_quot_step;
          md_cnt_reg  <= md_cnt_reg + 5'd1;
          if (md_cnt_reg == 5'd31) begin
            md_busy_reg <= 1'b0;
            hi_reg      <= md_rem_step;
            lo_reg      <= md_quot_step;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Self-checking bench for mips_cpu_bus. A small bus slave model serves
// instruction ROM at 0xBFC00000 and data RAM at 0x0, with programmable
// waitrequest stalls. Expected bus transfers are queued when each program
// is loaded and popped as the CPU completes transfers.
module tb_mips_cpu_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  mips_cpu_bus dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic [31:0] rom [0:127];
  logic [31:0] ram [0:511];
  int stall_fetch = 0;
  int stall_data  = 0;
  int stall_cnt;
  int stall_len;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    int          stalls;
  } bus_txn_t;

  bus_txn_t exp_q[$];

  // Monitor state (used only by the main initial process)
  int          stall_seen;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_be;
  logic [1:0]  hold_rw;

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    if (a[31:9] == BASE[31:9]) return rom[a[8:2]];
    if (a < 32'h800)           return ram[a[10:2]];
    return 32'h0;
  endfunction

  assign readdata = mem_lookup(address);

  always_comb begin
    stall_len   = (address[31:28] == 4'hB) ? stall_fetch : stall_data;
    waitrequest = (read || write) && (stall_cnt < stall_len);
  end

  always @(posedge clk) begin
    if (reset)                stall_cnt <= 0;
    else if (read || write)   stall_cnt <= waitrequest ? stall_cnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) rom[i] = 32'h0;
    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    exp_q.delete();
  endtask

  task automatic push_fetch(input int idx);
    exp_q.push_back('{1'b0, BASE + 32'(idx * 4), 32'h0, stall_fetch});
  endtask

  task automatic push_write(input logic [31:0] data);
    exp_q.push_back('{1'b1, 32'h400, data, stall_data});
  endtask

  task automatic push_read(input logic [31:0] addr);
    exp_q.push_back('{1'b0, addr, 32'h0, stall_data});
  endtask

  task automatic monitor_step();
    bus_txn_t t;
    if (read || write) begin
      if (waitrequest) begin
        if (stall_seen == 0) begin
          hold_addr  = address;
          hold_wdata = writedata;
          hold_be    = byteenable;
          hold_rw    = {read, write};
        end else begin
          check("hold_addr", address, hold_addr);
          check("hold_wdata", writedata, hold_wdata);
          check("hold_be", {28'd0, byteenable}, {28'd0, hold_be});
          check("hold_rw", {30'd0, read, write}, {30'd0, hold_rw});
        end
        stall_seen++;
      end else begin
        $display("[TB] %s addr=%h data=%h be=%b stalls=%0d", write ? "WR" : "RD",
                 address, write ? writedata : readdata, byteenable, stall_seen);
        if (exp_q.size() == 0) begin
          check("unexpected_txn", address, 32'hFFFF_FFFF);
        end else begin
          t = exp_q.pop_front();
          check("txn_kind", {31'd0, write}, {31'd0, t.is_write});
          check("txn_addr", address, t.addr);
          if (t.is_write) check("txn_wdata", writedata, t.data);
          check("txn_be", {28'd0, byteenable}, 32'hF);
          check("txn_stalls", 32'(stall_seen), 32'(t.stalls));
          check("rw_excl", {31'd0, read & write}, 32'h0);
        end
        if (write) ram[address[10:2]] = writedata;
        stall_seen = 0;
      end
    end
  endtask

  task automatic run_prog(input string name, input int max_cycles, input logic [31:0] exp_v0);
    int  cyc;
    bit  done;
    stall_seen = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read", {31'd0, read}, 32'h0);
    check("rst_write", {31'd0, write}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("first_read", {31'd0, read}, 32'h1);
    check("first_addr", address, BASE);
    check("first_be", {28'd0, byteenable}, 32'hF);
    check("first_active", {31'd0, active}, 32'h1);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < max_cycles) begin
      monitor_step();
      if (!active) done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_halted"}, {31'd0, active}, 32'h0);
    check({name, "_halt_addr"}, address, 32'h0);
    check({name, "_halt_rw"}, {30'd0, read, write}, 32'h0);
    check({name, "_q_drained"}, 32'(exp_q.size()), 32'h0);
    check({name, "_v0"}, register_v0, exp_v0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mul_hi, div_lo;

    // Program A: LUI/ORI builds -2 in $2, then JR $0 halts after its delay slot.
    clear_mem();
    stall_fetch = 0;
    stall_data  = 0;
    rom[0] = i_type(6'h0F, 5'd0, 5'd2, 16'hFFFF);
    rom[1] = i_type(6'h0D, 5'd2, 5'd2, 16'hFFFE);
    rom[2] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    rom[3] = 32'h0;
    for (int i = 0; i < 4; i++) push_fetch(i);
    run_prog("lui_ori", 500, 32'hFFFF_FFFE);

    // Program B: LW with a 3-cycle data stall and 1-cycle fetch stalls.
    clear_mem();
    stall_fetch = 1;
    stall_data  = 3;
    ram[256] = 32'h1234_5678;
    rom[0] = i_type(6'h23, 5'd0, 5'd2, 16'h0400);
    rom[1] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    rom[2] = 32'h0;
    push_fetch(0);
    push_read(32'h400);
    push_fetch(1);
    push_fetch(2);
    run_prog("lw_stall", 500, 32'h1234_5678);

    // Program C: SW then an unaligned LW (0x403) from the same word.
    clear_mem();
    stall_fetch = 0;
    stall_data  = 0;
    rom[0] = i_type(6'h0F, 5'd0, 5'd3, 16'hDEAD);
    rom[1] = i_type(6'h0D, 5'd3, 5'd3, 16'hBEEF);
    rom[2] = i_type(6'h2B, 5'd0, 5'd3, 16'h0400);
    rom[3] = i_type(6'h23, 5'd0, 5'd2, 16'h0403);
    rom[4] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    rom[5] = 32'h0;
    push_fetch(0); push_fetch(1); push_fetch(2);
    push_write(32'hDEAD_BEEF);
    push_fetch(3);
    push_read(32'h400);
    push_fetch(4); push_fetch(5);
    run_prog("sw_lw", 500, 32'hDEAD_BEEF);

    // Program D: taken BLTZAL; delay slot sets $2=5, $31 = branch PC + 8.
    clear_mem();
    rom[0] = i_type(6'h09, 5'd0, 5'd4, 16'hFFFF);
    rom[1] = i_type(6'h01, 5'd4, 5'b10000, 16'd3);
    rom[2] = i_type(6'h09, 5'd0, 5'd2, 16'd5);
    rom[3] = i_type(6'h09, 5'd0, 5'd2, 16'h0077);
    rom[4] = i_type(6'h09, 5'd0, 5'd2, 16'h0077);
    rom[5] = i_type(6'h2B, 5'd0, 5'd2, 16'h0400);
    rom[6] = r_type(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
    rom[7] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    rom[8] = 32'h0;
    push_fetch(0); push_fetch(1); push_fetch(2); push_fetch(5);
    push_write(32'd5);
    push_fetch(6); push_fetch(7); push_fetch(8);
    run_prog("bltzal", 500, 32'hBFC0_000C);

    // Program E: ALU ops, $0 discard, BNE/BEQ/JAL, with 2-cycle fetch stalls.
    clear_mem();
    stall_fetch = 2;
    stall_data  = 1;
    rom[0]  = i_type(6'h09, 5'd0, 5'd4, 16'hFFFF);
    rom[1]  = i_type(6'h09, 5'd0, 5'd5, 16'd2);
    rom[2]  = i_type(6'h0F, 5'd0, 5'd7, 16'h8000);
    rom[3]  = r_type(5'd5, 5'd4, 5'd6, 5'd0, 6'h23);
    rom[5]  = r_type(5'd4, 5'd5, 5'd6, 5'd0, 6'h2A);
    rom[7]  = r_type(5'd4, 5'd5, 5'd6, 5'd0, 6'h2B);
    rom[9]  = i_type(6'h0B, 5'd5, 5'd6, 16'hFFFF);
    rom[11] = r_type(5'd0, 5'd7, 5'd6, 5'd4, 6'h03);
    rom[13] = i_type(6'h09, 5'd0, 5'd0, 16'd5);
    rom[14] = i_type(6'h2B, 5'd0, 5'd0, 16'h0400);
    rom[15] = i_type(6'h0E, 5'd4, 5'd6, 16'h00FF);
    rom[17] = i_type(6'h05, 5'd5, 5'd5, 16'd5);
    rom[18] = i_type(6'h09, 5'd0, 5'd6, 16'd7);
    rom[20] = i_type(6'h04, 5'd5, 5'd5, 16'd2);
    rom[21] = i_type(6'h09, 5'd0, 5'd6, 16'd8);
    rom[22] = i_type(6'h09, 5'd0, 5'd6, 16'h0055);
    rom[24] = {6'h03, 26'h3F0_0040};
    rom[25] = i_type(6'h09, 5'd0, 5'd6, 16'd9);
    rom[65] = r_type(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
    rom[66] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    rom[67] = 32'h0;
    foreach (rom[i]) if (i inside {4, 6, 8, 10, 12, 16, 19, 23, 64})
      rom[i] = i_type(6'h2B, 5'd0, 5'd6, 16'h0400);
    for (int i = 0; i <= 21; i++) begin
      push_fetch(i);
      case (i)
        4:  push_write(32'd3);
        6:  push_write(32'd1);
        8:  push_write(32'd0);
        10: push_write(32'd1);
        12: push_write(32'hF800_0000);
        14: push_write(32'd0);
        16: push_write(32'hFFFF_FF00);
        19: push_write(32'd7);
        default: ;
      endcase
    end
    push_fetch(23); push_write(32'd8);
    push_fetch(24); push_fetch(25);
    push_fetch(64); push_write(32'd9);
    push_fetch(65); push_fetch(66); push_fetch(67);
    run_prog("alu_jal", 3000, 32'hBFC0_0068);

    // Program F: MULTU/MFHI, DIVU/MFLO, and DIVU by zero keeping LO.
`ifdef MULDIV_EN
    mul_hi = 32'h0000_0001;
    div_lo = 32'h7FFF_FFFF;
`else
    mul_hi = 32'h0;
    div_lo = 32'h0;
`endif
    clear_mem();
    stall_fetch = 0;
    stall_data  = 0;
    rom[0]  = i_type(6'h09, 5'd0, 5'd4, 16'hFFFF);
    rom[1]  = i_type(6'h09, 5'd0, 5'd5, 16'd2);
    rom[2]  = r_type(5'd4, 5'd5, 5'd0, 5'd0, 6'h19);
    rom[3]  = r_type(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
    rom[4]  = r_type(5'd4, 5'd5, 5'd0, 5'd0, 6'h1B);
    rom[5]  = r_type(5'd0, 5'd0, 5'd6, 5'd0, 6'h12);
    rom[6]  = i_type(6'h2B, 5'd0, 5'd6, 16'h0400);
    rom[7]  = r_type(5'd4, 5'd0, 5'd0, 5'd0, 6'h1B);
    rom[8]  = r_type(5'd0, 5'd0, 5'd6, 5'd0, 6'h12);
    rom[9]  = i_type(6'h2B, 5'd0, 5'd6, 16'h0400);
    rom[10] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    rom[11] = 32'h0;
    for (int i = 0; i <= 6; i++) push_fetch(i);
    push_write(div_lo);
    push_fetch(7); push_fetch(8); push_fetch(9);
    push_write(div_lo);
    push_fetch(10); push_fetch(11);
    run_prog("muldiv", 1000, mul_hi);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus.md
MIPS_CPU_BUS -- requirements
Module: mips_cpu_bus

Interface
REQ-001 The design SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 Port `active`, output, 1 bit: 1 while executing; 0 once halted.
REQ-005 Port `register_v0`, output, 32 bits: continuous copy of GPR $2.
REQ-006 Port `address`, output, 32 bits: byte address, always word-aligned (bits 1:0 = 0).
REQ-007 Port `write`, output, 1 bit: write request.
REQ-008 Port `read`, output, 1 bit: read request.
REQ-009 Port `waitrequest`, input, 1 bit: slave stall.
REQ-010 Port `writedata`, output, 32 bits: store data.
REQ-011 Port `byteenable`, output, 4 bits: byte lanes; bit n selects bits 8n+7:8n.
REQ-012 Port `readdata`, input, 32 bits: read data, valid in the cycle a read completes.

Function
REQ-013 States SHALL be FETCH, EXEC, MEM and HALT; each instruction uses FETCH, then EXEC, then MEM (LW/SW only), then FETCH.
REQ-014 FETCH: `read`=1, `address`=PC, `byteenable`=1111, and the state SHALL be held while `waitrequest`=1.
REQ-015 FETCH: the instruction SHALL be latched in the first cycle with `waitrequest`=0.
REQ-016 `read` and `write` SHALL never both be 1; `address`, `writedata` and `byteenable` SHALL stay stable while `waitrequest`=1.
REQ-017 Instructions: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, BGEZAL, BLTZAL, J, JAL, JR.
REQ-018 Arithmetic SHALL wrap modulo 2^32 with no overflow traps.
REQ-019 ANDI, ORI and XORI SHALL zero-extend the immediate; all other immediates SHALL be sign-extended.
REQ-020 SLT and SLTI SHALL compare signed; SLTU and SLTIU SHALL compare unsigned, with SLTIU still sign-extending its immediate.
REQ-021 Writes to $0 SHALL be discarded; $0 SHALL always read 0.
REQ-022 Branch target = PC+4 + (sign-extended imm << 2).
REQ-023 J and JAL target = {PC+4[31:28], imm26, 00}.
REQ-024 All branches and jumps SHALL have exactly one delay slot, executed whether or not the branch is taken.
REQ-025 JAL SHALL write PC+8 to $31; BGEZAL and BLTZAL SHALL write PC+8 to $31 even when not taken.
REQ-026 MEM for LW: `read`=1, `address` = rs + offset, byteenable=1111; rt is written when `waitrequest`=0.
REQ-027 MEM for SW: `write`=1, `writedata`=rt, byteenable=1111; the request completes when `waitrequest`=0.
REQ-028 Unaligned LW/SW SHALL have address bits 1:0 forced to 0; undefined opcodes SHALL execute as NOP.
REQ-029 Halt: when FETCH would start with PC = 0x00000000, the design SHALL enter HALT instead.
REQ-030 In HALT: `active`=0, `address`=0, `read`=0, `write`=0; the design SHALL stay in HALT until `reset`.
REQ-031 Halt SHALL occur only after the delay slot of the jump to 0 has completed.

Reset
REQ-032 On `clk` rising with `reset`=1, the design SHALL set: PC=0xBFC00000, all GPRs=0, state=FETCH, `active`=1.
REQ-033 While `reset`=1, `read`=0 and `write`=0.
REQ-034 Reset SHALL abort any in-flight instruction or bus transfer, including one stalled by `waitrequest`.
REQ-035 The first fetch (address 0xBFC00000) SHALL be issued in the cycle after `reset` deasserts.
REQ-036 `active` SHALL be 1 by the first rising edge after `reset` deasserts.

Configuration
REQ-037 Macro MULDIV_EN defined: MULTU and DIVU SHALL be supported, writing the 64-bit product to HI:LO, or the quotient to LO and the remainder to HI.
REQ-038 With MULDIV_EN: MFHI and MFLO SHALL be supported, HI and LO SHALL reset to 0, and DIVU by 0 SHALL leave HI and LO unchanged.
REQ-039 With MULDIV_EN: each MULTU/DIVU SHALL complete in EXEC within at most 34 cycles while bus requests are held at 0.
REQ-040 Macro MULDIV_EN undefined: MULTU, DIVU, MFHI and MFLO SHALL execute as NOP, and no HI/LO registers SHALL exist.

Verification
REQ-041 Test: reset, then `waitrequest`=0 constantly -> the first cycle shows read=1, address=0xBFC00000, byteenable=1111, and `active`=1.
REQ-042 Test: program "LUI $2,0xFFFF; ORI $2,$2,0xFFFE; JR $0; NOP" -> `register_v0`=0xFFFFFFFE (-2 signed), then active=0 and address=0.
REQ-043 Test: LW $2 from a word holding 0x12345678 with `waitrequest` high for 3 cycles -> the request is held stable for the 3 cycles, then `register_v0`=0x12345678.
REQ-044 Test: SW of 0xDEADBEEF to address 0x400, then LW from 0x400 -> write=1, writedata=0xDEADBEEF, byteenable=1111; `register_v0`=0xDEADBEEF.
REQ-045 Test: BLTZAL with rs=-1 whose delay slot is ADDIU $2,$0,5 -> $2=5, $31=PC+8, and the next fetch is at the branch target.
REQ-046 Test (MULDIV_EN): MULTU of 0xFFFFFFFF by 2, then MFHI $2 -> `register_v0`=1; with MULDIV_EN undefined -> `register_v0`=0.
